// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one 64-bit RAM port between instruction fetch and data access.
// One transaction in flight; ties alternate, with the data side winning the first tie after reset.
module mem_port_arbiter #(
    parameter logic [63:0] MEM_BASE = 64'h8000_0000,
    parameter int unsigned IDX_W    = 28
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             icache_cmd_valid,
    output logic             icache_cmd_ready,
    input  logic [63:0]      icache_cmd_payload_addr,
    output logic             icache_rsp_valid,
    output logic [31:0]      icache_rsp_payload_data,

    input  logic             dcache_cmd_valid,
    output logic             dcache_cmd_ready,
    input  logic [63:0]      dcache_cmd_payload_addr,
    input  logic             dcache_cmd_payload_wen,
    input  logic [63:0]      dcache_cmd_payload_wdata,
    input  logic [7:0]       dcache_cmd_payload_wstrb,
    input  logic [2:0]       dcache_cmd_payload_size,
    output logic             dcache_rsp_valid,
    output logic [63:0]      dcache_rsp_payload_data,

    output logic             mem_cmd_valid,
    input  logic             mem_cmd_ready,
    output logic [IDX_W-1:0] mem_cmd_idx,
    output logic             mem_cmd_wen,
    output logic [63:0]      mem_cmd_wdata,
    output logic [63:0]      mem_cmd_wmask,
    input  logic             mem_rsp_valid,
    input  logic [63:0]      mem_rsp_data
);

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STRB_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic              last_dc_q;
    logic              owner_dc_q;
    logic              off2_q;
    logic              wen_q;
    logic [IDX_W-1:0]  idx_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   wmask_q;

    logic              grant_ic_c;
    logic              grant_dc_c;
    logic [XLEN-1:0]   ic_off_c;
    logic [XLEN-1:0]   dc_off_c;
    logic [XLEN-1:0]   dc_wmask_c;
    logic              unused_c;

    assign ic_off_c = icache_cmd_payload_addr - MEM_BASE;
    assign dc_off_c = dcache_cmd_payload_addr - MEM_BASE;

    // Only the word index and the fetch half-word select are meaningful to the RAM.
    assign unused_c = ^{dcache_cmd_payload_size, ic_off_c[XLEN-1:IDX_W+3], ic_off_c[1:0],
                        dc_off_c[XLEN-1:IDX_W+3], dc_off_c[2:0]};

    always_comb begin
        dc_wmask_c = '0;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            dc_wmask_c[b*8 +: 8] = {8{dcache_cmd_payload_wstrb[b]}};
        end
    end

    // Next-state and grant decode; the requester that did not win last time takes a tie.
    always_comb begin
        state_d    = state_q;
        grant_ic_c = 1'b0;
        grant_dc_c = 1'b0;
        case (state_q)
            IDLE: begin
                grant_dc_c = dcache_cmd_valid && (!icache_cmd_valid || !last_dc_q);
                grant_ic_c = icache_cmd_valid && (!dcache_cmd_valid || last_dc_q);
                if (grant_ic_c || grant_dc_c) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_cmd_ready) begin
                    state_d = wen_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command capture at acceptance; held stable through ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_dc_q  <= 1'b0;
            owner_dc_q <= 1'b0;
            off2_q     <= 1'b0;
            wen_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else if (grant_dc_c) begin
            last_dc_q  <= 1'b1;
            owner_dc_q <= 1'b1;
            off2_q     <= 1'b0;
            wen_q      <= dcache_cmd_payload_wen;
            idx_q      <= dc_off_c[IDX_W+2:3];
            wdata_q    <= dcache_cmd_payload_wdata;
            wmask_q    <= dc_wmask_c;
        end else if (grant_ic_c) begin
            last_dc_q  <= 1'b0;
            owner_dc_q <= 1'b0;
            off2_q     <= ic_off_c[2];
            wen_q      <= 1'b0;
            idx_q      <= ic_off_c[IDX_W+2:3];
            wdata_q    <= '0;
            wmask_q    <= '0;
        end
    end

    assign icache_cmd_ready = reset_n && grant_ic_c;
    assign dcache_cmd_ready = reset_n && grant_dc_c;

    assign mem_cmd_valid = (state_q == ISSUE);
    assign mem_cmd_idx   = idx_q;
    assign mem_cmd_wen   = wen_q;
    assign mem_cmd_wdata = wdata_q;
    assign mem_cmd_wmask = wmask_q;

    assign icache_rsp_valid        = (state_q == WAIT) && mem_rsp_valid && !owner_dc_q;
    assign dcache_rsp_valid        = (state_q == WAIT) && mem_rsp_valid &&  owner_dc_q;
    assign icache_rsp_payload_data = off2_q ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
    assign dcache_rsp_payload_data = mem_rsp_data;

endmodule
